// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control and status bundle for countdown_timer
// Ports (master = controller side, slave = timer side):
//   load_val [WIDTH]     interval in prescaled ticks, latched on start
//   prescale [PRE_WIDTH] tick divider, one tick every prescale+1 cycles
//   periodic             1 = auto-reload, 0 = one-shot
//   start / stop / ack   launch, abort, clear expired
//   q [WIDTH]            current count
//   busy / tc / expired  running, terminal-count pulse, sticky expiry
interface countdown_timer_if #(
  parameter int WIDTH     = 20,
  parameter int PRE_WIDTH = 8
);
  logic [WIDTH-1:0]     load_val;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 periodic;
  logic                 start;
  logic                 stop;
  logic                 ack;
  logic [WIDTH-1:0]     q;
  logic                 busy;
  logic                 tc;
  logic                 expired;

  modport master (
    output load_val, prescale, periodic, start, stop, ack,
    input  q, busy, tc, expired
  );

  modport slave (
    input  load_val, prescale, periodic, start, stop, ack,
    output q, busy, tc, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable prescaled down-counting interval timer
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous active-high reset
//   sclr_i  synchronous clear, same effect as rst_i, overrides all inputs
//   bus     countdown_timer_if.slave: load_val/prescale/periodic/start/stop/ack
//           in, q/busy/tc/expired out (all outputs registered)
module countdown_timer #(
  parameter int WIDTH     = 20,
  parameter int PRE_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclr_i,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     load_q, load_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 per_q, per_d;
  logic                 busy_q, busy_d;
  logic                 tc_q, tc_d;
  logic                 expired_q, expired_d;

  // A start is honoured in IDLE and DONE, and in RUN unless stop is also high.
  logic launch;
  assign launch = bus.start &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                   ((state_q == ST_RUN) && !bus.stop));

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    load_d    = load_q;
    pre_cnt_d = pre_cnt_q;
    pre_d     = pre_q;
    per_d     = per_q;
    expired_d = expired_q;
    tc_d      = 1'b0;

    if (sclr_i) begin
      state_d   = ST_IDLE;
      q_d       = '0;
      load_d    = '0;
      pre_cnt_d = '0;
      pre_d     = '0;
      per_d     = 1'b0;
      expired_d = 1'b0;
    end else begin
      // ack clears first so that any set below in the same cycle wins.
      if (bus.ack) begin
        expired_d = 1'b0;
      end

      if (launch) begin
        if (bus.load_val != '0) begin
          load_d    = bus.load_val;
          pre_d     = bus.prescale;
          per_d     = bus.periodic;
          q_d       = bus.load_val;
          pre_cnt_d = bus.prescale;
          expired_d = 1'b0;
          state_d   = ST_RUN;
        end else begin
          // Zero interval expires immediately, even in periodic mode.
          q_d       = '0;
          tc_d      = 1'b1;
          expired_d = 1'b1;
          state_d   = ST_DONE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_DONE: begin
            if (bus.ack) begin
              state_d = ST_IDLE;
            end
          end
          ST_RUN: begin
            if (bus.stop) begin
              // Abort keeps q frozen so software can read the remainder.
              state_d = ST_IDLE;
            end else if (pre_cnt_q != '0) begin
              pre_cnt_d = pre_cnt_q - PRE_WIDTH'(1);
            end else begin
              pre_cnt_d = pre_q;
              if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
              end else if (q_q == WIDTH'(1)) begin
                tc_d      = 1'b1;
                expired_d = 1'b1;
                if (per_q) begin
                  // Reload straight from 1 so q never reads 0 while periodic.
                  q_d = load_q;
                end else begin
                  q_d     = '0;
                  state_d = ST_DONE;
                end
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      load_q    <= '0;
      pre_cnt_q <= '0;
      pre_q     <= '0;
      per_q     <= 1'b0;
      busy_q    <= 1'b0;
      tc_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      load_q    <= load_d;
      pre_cnt_q <= pre_cnt_d;
      pre_q     <= pre_d;
      per_q     <= per_d;
      busy_q    <= busy_d;
      tc_q      <= tc_d;
      expired_q <= expired_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.busy    = busy_q;
  assign bus.tc      = tc_q;
  assign bus.expired = expired_q;

endmodule
